// File: rtl/layer_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_stage_sequencer
// Purpose  : Inference scheduler. Issues one start pulse per Conv1/Conv2/Conv3/
//            FC1 stage, waits for the datapath done handshake under a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module layer_stage_sequencer #(
    parameter int N_STAGE     = 48,
    parameter int N_FC        = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iRUN,
    input  logic       iSTAGE_DONE,
    input  logic       iCLR_ERR,
    output logic       oSTART_BWN,
    output logic [3:0] oSTART_BNN,
    output logic [1:0] oLAYER,
    output logic [5:0] oSTAGE,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERR
);

    localparam logic [5:0]  c_CONV_LAST = 6'(N_STAGE - 1);
    localparam logic [5:0]  c_FC_LAST   = 6'(N_FC - 1);
    localparam logic [15:0] c_WD_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  c_LAYER_FC  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ADV   = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_layer;
    logic [5:0]  r_stage;
    logic [15:0] r_wdog;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= S_IDLE;
            r_layer <= 2'd0;
            r_stage <= 6'd0;
            r_wdog  <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iRUN) begin
                        r_state <= S_ISSUE;
                        r_layer <= 2'd0;
                        r_stage <= 6'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= 16'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (iSTAGE_DONE) begin
                        r_state <= S_ADV;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                S_ADV: begin
                    if (r_layer == c_LAYER_FC) begin
                        if (r_stage == c_FC_LAST) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_layer <= 2'd0;
                            r_stage <= 6'd0;
                        end else begin
                            r_stage <= r_stage + 6'd1;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_stage == c_CONV_LAST) begin
                        r_stage <= 6'd0;
                        r_layer <= r_layer + 2'd1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_stage <= r_stage + 6'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_wdog  <= 16'd0;
                end
                S_ERR: begin
                    // Layer/stage hold the failing position until the error is cleared.
                    if (iCLR_ERR) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                        r_layer <= 2'd0;
                        r_stage <= 6'd0;
                        r_wdog  <= 16'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Start strobes decode the registered state, so they last exactly the ISSUE cycle.
    always_comb begin
        oSTART_BWN = 1'b0;
        oSTART_BNN = 4'b0000;
        if (r_state == S_ISSUE) begin
            if (r_layer == 2'd0) begin
                oSTART_BWN = 1'b1;
            end else begin
                oSTART_BNN[r_layer] = 1'b1;
            end
        end
    end

    assign oLAYER = r_layer;
    assign oSTAGE = r_stage;
    assign oBUSY  = r_busy;
    assign oDONE  = r_done;
    assign oERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_layer_stage_sequencer.sv
`default_nettype none
// Bench for layer_stage_sequencer: vector table for the handshake corners,
// scoreboarded start-pulse sequence over full inferences, timeout and reset cases.
module tb_layer_stage_sequencer;

    localparam int c_NST = 48;
    localparam int c_NFC = 5;
    localparam int c_TO  = 8;
    localparam int c_PER_RUN = 3 * c_NST + c_NFC;

    logic       iCLK;
    logic       iRST;
    logic       iRUN;
    logic       iSTAGE_DONE;
    logic       iCLR_ERR;
    logic       oSTART_BWN;
    logic [3:0] oSTART_BNN;
    logic [1:0] oLAYER;
    logic [5:0] oSTAGE;
    logic       oBUSY;
    logic       oDONE;
    logic       oERR;

    layer_stage_sequencer #(
        .N_STAGE     (c_NST),
        .N_FC        (c_NFC),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iRUN        (iRUN),
        .iSTAGE_DONE (iSTAGE_DONE),
        .iCLR_ERR    (iCLR_ERR),
        .oSTART_BWN  (oSTART_BWN),
        .oSTART_BNN  (oSTART_BNN),
        .oLAYER      (oLAYER),
        .oSTAGE      (oSTAGE),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE),
        .oERR        (oERR)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Observed outputs packed as {layer, stage, busy, err, done, bwn, bnn}.
    logic [15:0] w_obs;
    assign w_obs = {oLAYER, oSTAGE, oBUSY, oERR, oDONE, oSTART_BWN, oSTART_BNN};

    function automatic logic [15:0] pk(input logic [1:0] l, input logic [5:0] s,
                                       input logic b, input logic e, input logic d,
                                       input logic bw, input logic [3:0] bn);
        return {l, s, b, e, d, bw, bn};
    endfunction

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Scoreboard of start codes {bwn, bnn}, one entry per expected start pulse.
    logic [4:0] exp_q[$];

    task automatic expect_run();
        for (int l = 0; l < 4; l++) begin
            for (int s = 0; s < ((l == 3) ? c_NFC : c_NST); s++) begin
                exp_q.push_back((l == 0) ? 5'b10000 : {1'b0, 4'(1 << l)});
            end
        end
    endtask

    int         mon_cyc  = 0;
    int         mon_last = -1;
    logic [4:0] mon_code;
    logic [4:0] mon_exp;

    initial begin
        forever begin
            @(negedge iCLK);
            mon_cyc++;
            if (!iRST) begin
                mon_last = -1;
            end else begin
                mon_code = {oSTART_BWN, oSTART_BNN};
                if (mon_code != 5'b00000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 32'(mon_code), 32'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("start_code", 32'(mon_code), 32'(mon_exp));
                    end
                    if (mon_last >= 0) check("start_gap_ge3", 32'(mon_cyc - mon_last >= 3), 32'd1);
                    mon_last = mon_cyc;
                end
            end
        end
    end

    // Responds with done in the WAIT cycle right after each start; stops at oDONE,
    // oERR, or once the absolute start count reaches stop_at (0 = run to the end).
    task automatic drive_run(input bit init_prev, input int starts_before, input int stop_at,
                             input bit toggle, output int starts_total);
        logic [1:0] sh;
        int  k, n, last_start, last_done;
        bit  fin, stopped, st;
        sh = {1'b0, init_prev};
        k = starts_before;
        n = 0;
        last_start = init_prev ? 0 : -1;
        last_done = -100;
        fin = 1'b0;
        stopped = 1'b0;
        while (!fin && !stopped && n < 1000) begin
            n++;
            iSTAGE_DONE = sh[1];
            if (sh[1]) last_done = n;
            if (toggle) iRUN = 1'($urandom_range(0, 1));
            tick();
            st = oSTART_BWN || (oSTART_BNN != 4'b0000);
            sh = {sh[0], st};
            if (st) begin
                k++;
                if (last_start >= 0) check("stage_period", 32'(n - last_start), 32'd3);
                last_start = n;
                if (stop_at > 0 && k == stop_at) stopped = 1'b1;
            end
            if (oDONE) begin
                fin = 1'b1;
                check("done_latency", 32'(n - last_done), 32'd1);
            end
            if (oERR) stopped = 1'b1;
        end
        iSTAGE_DONE = 1'b0;
        if (stop_at == 0) begin
            check("run_finished", 32'(fin), 32'd1);
            check("starts_per_run", 32'(k), 32'(c_PER_RUN));
        end else begin
            check("reached_stop_point", 32'(k), 32'(stop_at));
        end
        starts_total = k;
    endtask

    typedef struct {
        logic        run;
        logic        done;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[13];
    int   total;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Inputs are applied before an edge; expected outputs are those after it.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, pk(2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, pk(2'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, pk(2'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[11] = '{1'b0, 1'b1, 1'b0, pk(2'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, pk(2'd0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)};

        iRST = 1'b0;
        iRUN = 1'b0;
        iSTAGE_DONE = 1'b0;
        iCLR_ERR = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'(w_obs), 32'd0);
        iRST = 1'b1;
        tick();
        check("idle_after_release", 32'(w_obs), 32'd0);

        // Handshake corners: done during ISSUE is dropped, iRUN/iCLR_ERR ignored when busy.
        expect_run();
        for (int i = 0; i < 13; i++) begin
            iRUN = tbl[i].run;
            iSTAGE_DONE = tbl[i].done;
            iCLR_ERR = tbl[i].clr;
            tick();
            check($sformatf("vec%0d", i), 32'(w_obs), 32'(tbl[i].exp));
        end
        iRUN = 1'b0;
        iSTAGE_DONE = 1'b0;
        iCLR_ERR = 1'b0;
        drive_run(1'b1, 4, 0, 1'b0, total);
        tick();
        check("done_single_pulse", 32'(w_obs), 32'd0);
        check("queue_empty_run1", 32'(exp_q.size()), 32'd0);

        // iRUN held high: a new run starts straight after FIN -> IDLE.
        expect_run();
        iRUN = 1'b1;
        tick();
        check("run_start", 32'(w_obs), 32'(pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)));
        drive_run(1'b1, 1, 0, 1'b0, total);
        check("fin_busy", 32'(oBUSY), 32'd1);
        expect_run();
        tick();
        check("idle_after_fin", 32'(w_obs), 32'd0);
        tick();
        check("immediate_restart", 32'(w_obs), 32'(pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)));
        drive_run(1'b1, 1, 0, 1'b1, total);
        iRUN = 1'b0;
        tick();
        tick();
        check("idle_no_restart", 32'(w_obs), 32'd0);
        check("queue_empty_run3", 32'(exp_q.size()), 32'd0);

        // Watchdog: no done after the first Conv2 start.
        expect_run();
        iRUN = 1'b1;
        tick();
        iRUN = 1'b0;
        drive_run(1'b1, 1, c_NST + 1, 1'b0, total);
        check("conv2_first_start", 32'(w_obs), 32'(pk(2'd1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010)));
        repeat (c_TO) tick();
        check("wait_before_timeout", 32'(w_obs), 32'(pk(2'd1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        tick();
        check("timeout_err", 32'(w_obs), 32'(pk(2'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000)));
        iRUN = 1'b1;
        iSTAGE_DONE = 1'b1;
        repeat (3) tick();
        check("err_sticky", 32'(w_obs), 32'(pk(2'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000)));
        iRUN = 1'b0;
        iSTAGE_DONE = 1'b0;
        iCLR_ERR = 1'b1;
        tick();
        iCLR_ERR = 1'b0;
        check("err_cleared", 32'(w_obs), 32'd0);
        tick();
        check("idle_after_clear", 32'(w_obs), 32'd0);
        exp_q.delete();

        // Done arriving on the last WAIT cycle beats the timeout.
        expect_run();
        iRUN = 1'b1;
        tick();
        iRUN = 1'b0;
        repeat (c_TO) tick();
        check("wait_last_cycle", 32'(w_obs), 32'(pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        iSTAGE_DONE = 1'b1;
        tick();
        iSTAGE_DONE = 1'b0;
        check("done_wins_adv", 32'(w_obs), 32'(pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000)));
        tick();
        check("done_wins_next_issue", 32'(w_obs), 32'(pk(2'd0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)));

        // Continue to layer 2 stage 17, then reset asynchronously mid-WAIT.
        drive_run(1'b1, 2, 2 * c_NST + 18, 1'b0, total);
        check("stop_position", 32'(w_obs), 32'(pk(2'd2, 6'd17, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100)));
        tick();
        #2;
        iRST = 1'b0;
        #1;
        check("async_reset", 32'(w_obs), 32'd0);
        tick();
        tick();
        iRST = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        check("idle_until_run", 32'(w_obs), 32'd0);
        expect_run();
        iRUN = 1'b1;
        tick();
        iRUN = 1'b0;
        check("start_after_reset", 32'(w_obs), 32'(pk(2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000)));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
